// File: rtl/mem_wb_stage.sv
// MEM/WB pipeline register and writeback select, driving the register-file write port and WB forwarding data.
// Optional retired-instruction counter enabled by defining WB_RETIRE_COUNT_EN.
module mem_wb_stage #(
  parameter int unsigned XLEN       = 32,
  parameter int unsigned REG_ADDR_W = 5,
  parameter int unsigned CNT_W      = 64
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  stall,
  input  logic                  flush,
  input  logic                  mem_valid,
  input  logic                  dm_read_enable,
  input  logic                  dm_write_enable,
  input  logic [XLEN-1:0]       dm_read_data,
  input  logic [XLEN-1:0]       dm_data_bypass,
  input  logic [XLEN-1:0]       pc_plus4,
  input  logic [1:0]            wb_sel,
  input  logic [REG_ADDR_W-1:0] rd_addr,
  input  logic                  rd_write_enable,
  output logic                  wb_valid,
  output logic                  rf_write_enable,
  output logic [REG_ADDR_W-1:0] rf_write_addr,
  output logic [XLEN-1:0]       rf_write_data,
  output logic                  ls_conflict_err,
  output logic [CNT_W-1:0]      retire_count
);

  logic            conflict_c;
  logic            live_c;
  logic            rd_we_c;
  logic [XLEN-1:0] wb_data_c;

  // Writeback value is selected ahead of the register so rf_write_data is a flop output.
  always_comb begin
    conflict_c = mem_valid & dm_read_enable & dm_write_enable;
    live_c     = mem_valid & ~conflict_c;
    rd_we_c    = rd_write_enable & ~dm_write_enable;
    wb_data_c  = '0;
    unique case (wb_sel)
      2'b00:   wb_data_c = dm_data_bypass;
      2'b01:   wb_data_c = dm_read_data;
      2'b10:   wb_data_c = pc_plus4;
      default: wb_data_c = '0;
    endcase
  end

  // Write strobe is precomputed at capture so it is registered together with its qualifiers.
  always_ff @(posedge clk) begin
    if (rst) begin
      wb_valid        <= 1'b0;
      rf_write_enable <= 1'b0;
      rf_write_addr   <= '0;
      rf_write_data   <= '0;
      ls_conflict_err <= 1'b0;
    end else if (flush) begin
      wb_valid        <= 1'b0;
      rf_write_enable <= 1'b0;
    end else if (!stall) begin
      wb_valid        <= live_c;
      rf_write_enable <= live_c & rd_we_c & (rd_addr != '0);
      rf_write_addr   <= rd_addr;
      rf_write_data   <= wb_data_c;
      if (conflict_c) begin
        ls_conflict_err <= 1'b1;
      end
    end
  end

`ifdef WB_RETIRE_COUNT_EN
  logic [CNT_W-1:0] cnt_q;

  // A stalled instruction retires once, on the edge it leaves WB.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else if (wb_valid && !stall) begin
      cnt_q <= cnt_q + CNT_W'(1);
    end
  end

  assign retire_count = cnt_q;
`else
  assign retire_count = '0;
`endif

endmodule

// File: tb/tb_mem_wb_stage.sv
// Self-checking bench for mem_wb_stage: directed scenarios plus randomized traffic against a behavioural model.
module tb_mem_wb_stage;

  logic        clk = 1'b0;
  logic        rst, stall, flush, mem_valid, dm_read_enable, dm_write_enable;
  logic [31:0] dm_read_data, dm_data_bypass, pc_plus4;
  logic [1:0]  wb_sel;
  logic [4:0]  rd_addr;
  logic        rd_write_enable;
  logic        wb_valid, rf_write_enable, ls_conflict_err;
  logic [4:0]  rf_write_addr;
  logic [31:0] rf_write_data;
  logic [63:0] retire_count;

  // Expected WB-side view of the pipeline
  logic        ev, ewe, eerr, eknown;
  logic [4:0]  eaddr;
  logic [31:0] edata;
  logic [63:0] ecnt;
  int          cmp_count  = 0;
  int          fail_count = 0;

  mem_wb_stage dut (
    .clk(clk), .rst(rst), .stall(stall), .flush(flush), .mem_valid(mem_valid),
    .dm_read_enable(dm_read_enable), .dm_write_enable(dm_write_enable),
    .dm_read_data(dm_read_data), .dm_data_bypass(dm_data_bypass), .pc_plus4(pc_plus4),
    .wb_sel(wb_sel), .rd_addr(rd_addr), .rd_write_enable(rd_write_enable),
    .wb_valid(wb_valid), .rf_write_enable(rf_write_enable), .rf_write_addr(rf_write_addr),
    .rf_write_data(rf_write_data), .ls_conflict_err(ls_conflict_err), .retire_count(retire_count)
  );

  always #5 clk = ~clk;

  task automatic idle();
    rst = 0; stall = 0; flush = 0; mem_valid = 0; dm_read_enable = 0; dm_write_enable = 0;
    dm_read_data = 0; dm_data_bypass = 0; pc_plus4 = 0; wb_sel = 0; rd_addr = 0; rd_write_enable = 0;
  endtask

  task automatic instr(input logic rd_en, input logic wr_en, input logic [1:0] sel,
                       input logic [4:0] rd, input logic we, input logic [31:0] val);
    idle();
    mem_valid = 1; dm_read_enable = rd_en; dm_write_enable = wr_en; wb_sel = sel;
    rd_addr = rd; rd_write_enable = we;
    dm_read_data = val; dm_data_bypass = ~val; pc_plus4 = val ^ 32'h5A5A_0004;
  endtask

  // Model: one rising edge of the pipeline, applied from the current inputs, then advance the clock.
  task automatic tick();
    logic        conf;
    logic [31:0] d;
    conf = mem_valid & dm_read_enable & dm_write_enable;
    case (wb_sel)
      2'd0:    d = dm_data_bypass;
      2'd1:    d = dm_read_data;
      2'd2:    d = pc_plus4;
      default: d = 32'd0;
    endcase
    if (rst) begin
      ev = 0; ewe = 0; eaddr = 0; edata = 0; eerr = 0; ecnt = 0; eknown = 1;
    end else begin
`ifdef WB_RETIRE_COUNT_EN
      if (ev && !stall) ecnt = ecnt + 64'd1;
`endif
      if (flush) begin
        ev = 0; ewe = 0; eknown = 0;
      end else if (!stall) begin
        ev = mem_valid && !conf;
        ewe = ev && rd_write_enable && !dm_write_enable && (rd_addr != 5'd0);
        eaddr = rd_addr; edata = d; eknown = 1;
        if (conf) eerr = 1;
      end
    end
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    idle();
    rst = 1; mem_valid = 1; rd_addr = 5'd5; wb_sel = 2'b00; rd_write_enable = 1; dm_data_bypass = 32'hDEAD_BEEF;
    for (int i = 0; i < 2; i++) begin
      tick();
      cmp_count++;
      if ({wb_valid, rf_write_enable, rf_write_addr, rf_write_data, ls_conflict_err, retire_count} !== '0) begin
        fail_count++;
        $display("FAIL reset_cycle%0d: got v=%b we=%b a=%0d d=%h err=%b cnt=%0d, want all 0",
                 i, wb_valid, rf_write_enable, rf_write_addr, rf_write_data, ls_conflict_err, retire_count);
      end
    end
    rst = 0;
    #2;
    cmp_count++;
    if ({wb_valid, rf_write_enable, rf_write_addr, rf_write_data, ls_conflict_err, retire_count} !== '0) begin
      fail_count++;
      $display("FAIL reset_after: got v=%b we=%b a=%0d d=%h, want all 0",
               wb_valid, rf_write_enable, rf_write_addr, rf_write_data);
    end
  endtask

  task automatic test_load();
    instr(1, 0, 2'b01, 5'd7, 1, 32'hFFFF_FF80);
    tick();
    cmp_count++;
    if ({wb_valid, rf_write_enable, rf_write_addr, rf_write_data} !== {1'b1, 1'b1, 5'd7, 32'hFFFF_FF80}) begin
      fail_count++;
      $display("FAIL load: got v=%b we=%b a=%0d d=%h, want 1 1 7 ffffff80",
               wb_valid, rf_write_enable, rf_write_addr, rf_write_data);
    end
  endtask

  task automatic test_store_jal();
    instr(0, 1, 2'b00, 5'd3, 1, 32'h0000_1111);
    tick();
    cmp_count++;
    if ({wb_valid, rf_write_enable} !== 2'b10) begin
      fail_count++;
      $display("FAIL store: got v=%b we=%b, want v=1 we=0", wb_valid, rf_write_enable);
    end
    instr(0, 0, 2'b10, 5'd0, 1, 32'h0000_2222);
    pc_plus4 = 32'h0000_0104;
    tick();
    cmp_count++;
    if ({wb_valid, rf_write_enable, rf_write_addr, rf_write_data} !== {1'b1, 1'b0, 5'd0, 32'h0000_0104}) begin
      fail_count++;
      $display("FAIL jal_x0: got v=%b we=%b a=%0d d=%h, want 1 0 0 00000104",
               wb_valid, rf_write_enable, rf_write_addr, rf_write_data);
    end
  endtask

  task automatic test_stall_flush();
    instr(0, 0, 2'b00, 5'd9, 1, 32'h0);
    dm_data_bypass = 32'h0000_1234;
    tick();
    for (int i = 0; i < 3; i++) begin
      instr(1, 0, 2'b01, 5'($urandom_range(1, 31)), 1, $urandom);
      stall = 1;
      tick();
      cmp_count++;
      if ({wb_valid, rf_write_enable, rf_write_addr, rf_write_data} !== {1'b1, 1'b1, 5'd9, 32'h0000_1234}) begin
        fail_count++;
        $display("FAIL stall_hold%0d: got v=%b we=%b a=%0d d=%h, want 1 1 9 00001234",
                 i, wb_valid, rf_write_enable, rf_write_addr, rf_write_data);
      end
    end
    stall = 1; flush = 1;
    tick();
    cmp_count++;
    if ({wb_valid, rf_write_enable} !== 2'b00) begin
      fail_count++;
      $display("FAIL stall_flush: got v=%b we=%b, want 0 0", wb_valid, rf_write_enable);
    end
  endtask

  task automatic test_conflict();
    instr(1, 1, 2'b01, 5'd4, 1, 32'hCAFE_0000);
    tick();
    cmp_count++;
    if ({wb_valid, rf_write_enable, ls_conflict_err} !== 3'b001) begin
      fail_count++;
      $display("FAIL conflict: got v=%b we=%b err=%b, want 0 0 1", wb_valid, rf_write_enable, ls_conflict_err);
    end
    idle(); stall = 1; tick();
    idle(); flush = 1; tick();
    instr(1, 0, 2'b01, 5'd6, 1, 32'h1); tick();
    cmp_count++;
    if (ls_conflict_err !== 1'b1) begin
      fail_count++;
      $display("FAIL conflict_sticky: got err=%b, want 1", ls_conflict_err);
    end
    idle(); rst = 1; tick();
    idle(); dm_read_enable = 1; dm_write_enable = 1; rd_addr = 5'd4; rd_write_enable = 1;
    tick();
    cmp_count++;
    if ({wb_valid, ls_conflict_err} !== 2'b00) begin
      fail_count++;
      $display("FAIL conflict_invalid: got v=%b err=%b, want 0 0", wb_valid, ls_conflict_err);
    end
  endtask

  task automatic test_retire_count();
    idle(); rst = 1; tick();
`ifdef WB_RETIRE_COUNT_EN
    idle();
    force dut.cnt_q = 64'hFFFF_FFFF_FFFF_FFFE;
    #1;
    release dut.cnt_q;
    ecnt = 64'hFFFF_FFFF_FFFF_FFFE;
    instr(0, 0, 2'b00, 5'd1, 1, 32'h10); tick();
    instr(1, 0, 2'b01, 5'd2, 1, 32'h20); tick();
    idle(); stall = 1; tick();
    instr(0, 1, 2'b00, 5'd3, 0, 32'h30); tick();
    idle(); tick();
    idle(); tick();
    cmp_count++;
    if (retire_count !== 64'd1) begin
      fail_count++;
      $display("FAIL retire_wrap: got %h, want 0000000000000001", retire_count);
    end
`else
    for (int i = 0; i < 4; i++) begin
      instr(0, 0, 2'b00, 5'(i + 1), 1, 32'(i)); tick();
    end
    idle(); tick();
    cmp_count++;
    if (retire_count !== 64'd0) begin
      fail_count++;
      $display("FAIL retire_tied: got %h, want 0", retire_count);
    end
`endif
  endtask

  task automatic test_random();
    for (int n = 0; n < 400; n++) begin
      instr(1'($urandom), 1'($urandom), 2'($urandom), 5'($urandom_range(0, 3) == 0 ? 0 : $urandom), 1'($urandom), $urandom);
      mem_valid = ($urandom_range(0, 3) != 0);
      if ($urandom_range(0, 3) == 0) dm_write_enable = 0;
      stall = ($urandom_range(0, 5) == 0);
      flush = ($urandom_range(0, 7) == 0);
      rst   = ($urandom_range(0, 63) == 0);
      tick();
      cmp_count++;
      if ({wb_valid, rf_write_enable, ls_conflict_err, retire_count} !== {ev, ewe, eerr, ecnt}) begin
        fail_count++;
        $display("FAIL rand_ctrl@%0d: got v=%b we=%b err=%b cnt=%0d, want v=%b we=%b err=%b cnt=%0d",
                 n, wb_valid, rf_write_enable, ls_conflict_err, retire_count, ev, ewe, eerr, ecnt);
      end
      if (eknown) begin
        cmp_count++;
        if ({rf_write_addr, rf_write_data} !== {eaddr, edata}) begin
          fail_count++;
          $display("FAIL rand_data@%0d: got a=%0d d=%h, want a=%0d d=%h",
                   n, rf_write_addr, rf_write_data, eaddr, edata);
        end
      end
    end
  endtask

  initial begin
    idle();
    ev = 0; ewe = 0; eerr = 0; eknown = 0; eaddr = 0; edata = 0; ecnt = 0;
    test_reset();
    test_load();
    test_store_jal();
    test_stall_flush();
    test_conflict();
    test_retire_count();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_count, fail_count);
    $finish;
  end

endmodule
